// File: rtl/sram_8t_array.sv
// ---------------------------------------------------------------------------
// sram_8t_array
//
// Word-organised scratch array with one write port and one read port (1W1R),
// modelled on 8T storage: the write wordline/bitlines are independent of
// the read wordline, so a write and a read can happen in the same cycle.
//
// After reset an automatic clear sequence writes zero to every word, one
// word per clock. The ports are ignored until it finishes. Reads are
// registered with a valid flag. Accesses to addresses >= DEPTH are dropped
// (write) or return zero (read), and raise a one-cycle addr_err pulse.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   we         write enable (write wordline)
//   waddr      write address
//   wdata      write data (write bitlines)
//   wmask      per-bit write mask, 1 = bit is written
//   re         read enable (read wordline)
//   raddr      read address
//   rdata      registered read data, forced to zero when not valid
//   rvalid     rdata holds a read result this cycle
//   init_busy  clear sequence in progress, ports are ignored
//   addr_err   one-cycle pulse after an out-of-range access on either port
// ---------------------------------------------------------------------------
module sram_8t_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              init_busy,
    output logic              addr_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                addr_err_q, addr_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                waddr_ok, raddr_ok;
    logic [ADDR_W-1:0]   widx, ridx;
    logic [DATA_W-1:0]   wr_old, rd_old, merged;
    logic                run, wr_fire, rd_fire, collide;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    assign waddr_ok = ({1'b0, waddr} < DEPTH_EXT);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_EXT);

    // Out-of-range addresses are steered to word 0 so the array is never
    // indexed past its end; the result is discarded in that case anyway.
    assign widx   = waddr_ok ? waddr : '0;
    assign ridx   = raddr_ok ? raddr : '0;
    assign wr_old = mem[widx];
    assign rd_old = mem[ridx];

    // Per-bit merge of the new data into the stored word under wmask.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_merge
        assign merged[gi] = wmask[gi] ? wdata[gi] : wr_old[gi];
    end

    assign run     = (state_q == ST_RUN);
    assign wr_fire = run && we && waddr_ok;
    assign rd_fire = run && re && raddr_ok;
    // A zero mask still counts as a write for collision purposes.
    assign collide = wr_fire && rd_fire && (waddr == raddr);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rdata_d    = '0;
        rvalid_d   = 1'b0;
        addr_err_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ADDR_W'(ptr_q);
                mem_wdata = '0;
                // Pointer saturates on the last word; leaving INIT on the
                // same edge makes the sequence exactly DEPTH cycles long.
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                mem_we     = wr_fire;
                mem_waddr  = waddr;
                mem_wdata  = merged;
                rvalid_d   = re;
                if (rd_fire) begin
                    rdata_d = ((BYPASS != 0) && collide) ? merged : rd_old;
                end
                // Both ports out of range in one cycle still give one pulse.
                addr_err_d = (we && !waddr_ok) || (re && !raddr_ok);
            end
            default: begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage has no reset; it is cleared by the INIT sequence instead.
    // Writes are held off while reset is asserted so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign addr_err  = addr_err_q;
    assign init_busy = (state_q == ST_INIT);

endmodule

// File: tb/tb_sram_8t_array.sv
module tb_sram_8t_array;

    // Instance A: default geometry with bypass. Instance B: 12 words in a
    // 4-bit address space without bypass, so addresses 12..15 are invalid.
    localparam int DEP_A = 16;
    localparam int DEP_B = 12;

    logic       clk;
    logic       rst_n;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [7:0] wmask;
    logic       re;
    logic [3:0] raddr;

    logic [7:0] rdata_a, rdata_b;
    logic       rvalid_a, rvalid_b;
    logic       busy_a, busy_b;
    logic       err_a, err_b;

    int checks = 0;
    int errors = 0;

    sram_8t_array #(.DATA_W(8), .DEPTH(DEP_A), .ADDR_W(4), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata_a),
        .rvalid(rvalid_a), .init_busy(busy_a), .addr_err(err_a)
    );

    sram_8t_array #(.DATA_W(8), .DEPTH(DEP_B), .ADDR_W(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata_b),
        .rvalid(rvalid_b), .init_busy(busy_b), .addr_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_mem [2][16];
    int         init_left [2];
    logic [7:0] e_rd [2];
    logic       e_rv [2];
    logic       e_err [2];

    function automatic int dep_of(input int i);
        return (i == 0) ? DEP_A : DEP_B;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            init_left[i] = dep_of(i);
            e_rd[i]  = 8'h00;
            e_rv[i]  = 1'b0;
            e_err[i] = 1'b0;
        end
    endtask

    // One clock edge of the array, evaluated from the stated rules.
    task automatic model_step(input int i);
        int         d;
        logic       wok, rok;
        logic [7:0] old_word;
        d = dep_of(i);
        if (init_left[i] > 0) begin
            m_mem[i][d - init_left[i]] = 8'h00;
            init_left[i] = init_left[i] - 1;
            e_rd[i]  = 8'h00;
            e_rv[i]  = 1'b0;
            e_err[i] = 1'b0;
        end else begin
            wok = (int'(waddr) < d);
            rok = (int'(raddr) < d);
            old_word = rok ? m_mem[i][raddr] : 8'h00;
            if (we && wok)
                m_mem[i][waddr] = (m_mem[i][waddr] & ~wmask) | (wdata & wmask);
            e_rv[i] = re;
            if (re && rok)
                e_rd[i] = (i == 0) ? m_mem[i][raddr] : old_word;
            else
                e_rd[i] = 8'h00;
            e_err[i] = (we && !wok) || (re && !rok);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance one clock: the edge captures the inputs, the model follows,
    // and all outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        chk("a_rdata",  rdata_a,  e_rd[0]);
        chk("a_rvalid", rvalid_a, e_rv[0]);
        chk("a_err",    err_a,    e_err[0]);
        chk("a_busy",   busy_a,   init_left[0] > 0);
        chk("b_rdata",  rdata_b,  e_rd[1]);
        chk("b_rvalid", rvalid_b, e_rv[1]);
        chk("b_err",    err_b,    e_err[1]);
        chk("b_busy",   busy_b,   init_left[1] > 0);
        $display("t=%0t we=%0b wa=%0d wd=%02h wm=%02h re=%0b ra=%0d | A %02h/%0b/%0b B %02h/%0b/%0b",
                 $time, we, waddr, wdata, wmask, re, raddr,
                 rdata_a, rvalid_a, err_a, rdata_b, rvalid_b, err_b);
    endtask

    task automatic drive(input logic w, input logic [3:0] wa, input logic [7:0] wd,
                         input logic [7:0] wm, input logic r, input logic [3:0] ra);
        we = w; waddr = wa; wdata = wd; wmask = wm; re = r; raddr = ra;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0);
    endtask

    // Counts cycles with init_busy high after release (bounded).
    task automatic count_init(input bit random_inputs);
        int n_a, n_b;
        n_a = 0;
        n_b = 0;
        for (int c = 0; c < 40; c++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) n_a++;
            if (busy_b) n_b++;
            if (random_inputs)
                drive(1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'hFF,
                      1'b1, 4'($urandom_range(0, 15)));
            tick();
        end
        chk("lit_init_len_a", n_a, 16);
        chk("lit_init_len_b", n_b, 12);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        chk("lit_rst_rdata",  rdata_a,  8'h00);
        chk("lit_rst_rvalid", rvalid_a, 1'b0);
        chk("lit_rst_busy",   busy_a,   1'b1);
        chk("lit_rst_err",    err_b,    1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        count_init(1'b0);

        // Poke word 3, then reset and confirm the clear sequence wiped it.
        drive(1'b1, 4'd3, 8'h5A, 8'hFF, 1'b0, 4'd0); tick();
        idle(); tick();
        rst_n = 1'b0; model_reset();
        tick();
        rst_n = 1'b1;
        count_init(1'b0);
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3); tick();
        chk("lit_clear_a", rdata_a, 8'h00);
        chk("lit_clear_v", rvalid_a, 1'b1);

        // Basic write then read, then idle.
        drive(1'b1, 4'd5, 8'hA5, 8'hFF, 1'b0, 4'd0); tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5); tick();
        chk("lit_basic_a", rdata_a, 8'hA5);
        chk("lit_basic_b", rdata_b, 8'hA5);
        chk("lit_basic_v", rvalid_a, 1'b1);
        idle(); tick();
        chk("lit_idle_v", rvalid_a, 1'b0);
        chk("lit_idle_d", rdata_a, 8'h00);

        // Masked write.
        drive(1'b1, 4'd2, 8'hFF, 8'hFF, 1'b0, 4'd0); tick();
        drive(1'b1, 4'd2, 8'h00, 8'h0F, 1'b0, 4'd0); tick();
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2); tick();
        chk("lit_mask_a", rdata_a, 8'hF0);
        chk("lit_mask_b", rdata_b, 8'hF0);

        // Collision: bypass on A, old data on B, write completes on both.
        drive(1'b1, 4'd7, 8'h11, 8'hFF, 1'b0, 4'd0); tick();
        drive(1'b1, 4'd7, 8'h22, 8'hFF, 1'b1, 4'd7); tick();
        chk("lit_coll_a", rdata_a, 8'h22);
        chk("lit_coll_b", rdata_b, 8'h11);
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd7); tick();
        chk("lit_after_a", rdata_a, 8'h22);
        chk("lit_after_b", rdata_b, 8'h22);

        // Out of range on B only (address 13).
        drive(1'b1, 4'd13, 8'h77, 8'hFF, 1'b0, 4'd0); tick();
        chk("lit_oor_werr_b", err_b, 1'b1);
        chk("lit_oor_werr_a", err_a, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd13); tick();
        chk("lit_oor_rerr_b", err_b, 1'b1);
        chk("lit_oor_rd_b", rdata_b, 8'h00);
        chk("lit_oor_rv_b", rvalid_b, 1'b1);
        chk("lit_oor_rd_a", rdata_a, 8'h77);
        idle(); tick();
        chk("lit_oor_pulse_end", err_b, 1'b0);
        // Both ports out of range: a single pulse.
        drive(1'b1, 4'd14, 8'h33, 8'hFF, 1'b1, 4'd15); tick();
        chk("lit_oor_both", err_b, 1'b1);
        idle(); tick();
        chk("lit_oor_both_end", err_b, 1'b0);
        // Sweep all words; model compare covers every address.
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'(a)); tick();
        end

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] wa;
            wa = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), wa, 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
            tick();
        end

        // Reset in the middle of a read.
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5); tick();
        #2;
        rst_n = 1'b0; model_reset();
        #1;
        chk("lit_midrst_rv_a", rvalid_a, 1'b0);
        chk("lit_midrst_rv_b", rvalid_b, 1'b0);
        chk("lit_midrst_busy", busy_a, 1'b1);
        tick();
        rst_n = 1'b1;
        count_init(1'b1);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'(a)); tick();
            chk("lit_cleared_a", rdata_a, 8'h00);
            chk("lit_cleared_v", rvalid_a, 1'b1);
        end
        idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
